// File: rtl/sccb_master_if.sv
// rtl/sccb_master_if.sv - request handshake and SCCB pin bundle for sccb_master
//
// Purpose: groups the configuration-sequencer handshake and the SIO_C/SIO_D
// pin signals into one bundle shared by the bus master and its surroundings.
//
// Signals:
//   sccb_start    sequencer -> master  write request, level-sensitive
//   sccb_address  sequencer -> master  register sub-address, sampled on acceptance
//   sccb_data     sequencer -> master  register data, sampled on acceptance
//   sccb_ready    master -> sequencer  idle and able to accept a request
//   ack_err       master -> sequencer  don't-care bit read back high (sticky)
//   sioc          master -> pad        SIO_C, push-pull
//   siod_out      master -> pad        SIO_D output value
//   siod_oe       master -> pad        SIO_D output enable, 1 = drive
//   siod_in       pad -> master        SIO_D pad readback
//
// Modports: master (used by sccb_master), slave (sequencer and pad side).

interface sccb_master_if;
    logic       sccb_start;
    logic [7:0] sccb_address;
    logic [7:0] sccb_data;
    logic       sccb_ready;
    logic       ack_err;
    logic       sioc;
    logic       siod_out;
    logic       siod_oe;
    logic       siod_in;

    modport master (
        input  sccb_start,
        input  sccb_address,
        input  sccb_data,
        input  siod_in,
        output sccb_ready,
        output ack_err,
        output sioc,
        output siod_out,
        output siod_oe
    );

    modport slave (
        output sccb_start,
        output sccb_address,
        output sccb_data,
        output siod_in,
        input  sccb_ready,
        input  ack_err,
        input  sioc,
        input  siod_out,
        input  siod_oe
    );
endinterface

// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB three-phase write master (OV7670 register writes)
//
// Purpose: accepts one sub-address/data pair over a start/ready handshake and
// serialises START, device ID, sub-address, data and STOP onto SIO_C/SIO_D.
// Every bit lasts four quarters of QUARTER_CYCLES clk_25M cycles; SIO_C is
// low in quarters 0-1 and high in quarters 2-3, SIO_D changes at quarter 0.
//
// Parameters:
//   DEV_ADDR        SCCB write ID sent in phase 1, MSB first
//   QUARTER_CYCLES  clk_25M cycles per quarter bit, 2..1023
//
// Ports:
//   clk_25M   the only clock
//   rst_25M   synchronous, active-high reset
//   bus       sccb_master_if.master (handshake + SIO_C/SIO_D pins)
//
// Configuration macro: SCCB_ACK_CHECK_EN
//   defined   : siod_in is sampled on the last cycle of quarter 2 of each
//               don't-care bit; a 1 sets ack_err until the next acceptance
//   undefined : siod_in is unused and ack_err is tied to 0

module sccb_master #(
    parameter logic [7:0] DEV_ADDR       = 8'h42,
    parameter int         QUARTER_CYCLES = 62
) (
    input  logic          clk_25M,
    input  logic          rst_25M,
    sccb_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        SHIFT,
        STOP
    } state_t;

    localparam logic [9:0] QC_LAST  = 10'(QUARTER_CYCLES - 1);
    localparam logic [4:0] LAST_BIT = 5'd26;
    localparam logic [4:0] DC_POS   = 5'd8;

    state_t     state, state_n;
    logic [9:0] qcnt, qcnt_n;
    logic [1:0] qidx, qidx_n;
    logic [4:0] bidx, bidx_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] data_q, data_n;
    logic       sioc_q, sioc_n;
    logic       siod_q, siod_n;
    logic       oe_q, oe_n;
    logic       ready_q, ready_n;
    logic       quarter_done;
    logic [4:0] pos_n;
    logic [2:0] sel_n;
    logic [7:0] byte_n;

    // Position of a frame bit inside its 9-bit phase; 8 is the don't-care bit.
    function automatic logic [4:0] bit_pos(input logic [4:0] b);
        if (b < 5'd9) begin
            return b;
        end else if (b < 5'd18) begin
            return b - 5'd9;
        end else begin
            return b - 5'd18;
        end
    endfunction

    assign quarter_done = (qcnt == QC_LAST);

    always_comb begin : next_state_logic
        state_n = state;
        qcnt_n  = qcnt;
        qidx_n  = qidx;
        bidx_n  = bidx;
        addr_n  = addr_q;
        data_n  = data_q;
        case (state)
            SETTLE: begin
                state_n = IDLE;
            end
            IDLE: begin
                if (bus.sccb_start) begin
                    state_n = START;
                    qcnt_n  = '0;
                    qidx_n  = '0;
                    bidx_n  = '0;
                    addr_n  = bus.sccb_address;
                    data_n  = bus.sccb_data;
                end
            end
            START, SHIFT, STOP: begin
                if (!quarter_done) begin
                    qcnt_n = qcnt + 10'd1;
                end else begin
                    qcnt_n = '0;
                    qidx_n = qidx + 2'd1;
                    if (qidx == 2'd3) begin
                        case (state)
                            START: begin
                                state_n = SHIFT;
                                bidx_n  = '0;
                            end
                            SHIFT: begin
                                if (bidx == LAST_BIT) begin
                                    state_n = STOP;
                                end else begin
                                    bidx_n = bidx + 5'd1;
                                end
                            end
                            default: begin
                                state_n = SETTLE;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_n = SETTLE;
            end
        endcase
    end

    // Pin values are decoded from the next position so that every output
    // comes straight from a flop that changes together with the state.
    always_comb begin : output_decode
        sioc_n  = 1'b1;
        siod_n  = 1'b1;
        oe_n    = 1'b1;
        pos_n   = bit_pos(bidx_n);
        sel_n   = 3'd7 - pos_n[2:0];
        ready_n = (state_n == IDLE);
        if (bidx_n < 5'd9) begin
            byte_n = DEV_ADDR;
        end else if (bidx_n < 5'd18) begin
            byte_n = addr_n;
        end else begin
            byte_n = data_n;
        end
        case (state_n)
            START: begin
                siod_n = ~qidx_n[1];
            end
            SHIFT: begin
                sioc_n = qidx_n[1];
                if (pos_n == DC_POS) begin
                    oe_n = 1'b0;
                end else begin
                    siod_n = byte_n[sel_n];
                end
            end
            STOP: begin
                sioc_n = qidx_n[1];
                siod_n = (qidx_n == 2'd3);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_25M) begin
        if (rst_25M) begin
            state   <= SETTLE;
            qcnt    <= '0;
            qidx    <= '0;
            bidx    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            qcnt    <= qcnt_n;
            qidx    <= qidx_n;
            bidx    <= bidx_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            sioc_q  <= sioc_n;
            siod_q  <= siod_n;
            oe_q    <= oe_n;
            ready_q <= ready_n;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic ack_q, ack_n, ack_sample;

    // Last cycle of quarter 2 of a don't-care bit: SIO_C has been high for a
    // full quarter, so the slave's level on SIO_D is settled.
    assign ack_sample = (state == SHIFT) && (qidx == 2'd2) && quarter_done &&
                        (bit_pos(bidx) == DC_POS);

    always_comb begin : ack_logic
        ack_n = ack_q;
        if (state == IDLE && bus.sccb_start) begin
            ack_n = 1'b0;
        end else if (ack_sample && bus.siod_in) begin
            ack_n = 1'b1;
        end
    end

    always_ff @(posedge clk_25M) begin
        if (rst_25M) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_n;
        end
    end

    assign bus.ack_err = ack_q;
`else
    logic unused_siod_in;
    assign unused_siod_in = bus.siod_in;
    assign bus.ack_err    = 1'b0;
`endif

    assign bus.sccb_ready = ready_q;
    assign bus.sioc       = sioc_q;
    assign bus.siod_out   = siod_q;
    assign bus.siod_oe    = oe_q;

endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB (OV7670 three-phase write) bus master that executes single-register writes requested by the camera configuration sequencer. It accepts a sub-address/data pair over a start/ready handshake and serialises START, device ID, sub-address, data and STOP onto SIO_C/SIO_D. It sits between the configuration sequencer and the camera pins; pad tristating is done at top level.

## Interface
- `DEV_ADDR`, 8'h42: SCCB write ID sent in phase 1, MSB first.
- `QUARTER_CYCLES`, 62: clk_25M cycles per quarter bit. One bit is four quarters, so SIO_C ≈ 100.8 kHz. Legal values are 2 to 1023.
- `clk_25M` input 1: the only clock.
- `rst_25M` input 1: synchronous, active-high reset.
- `sccb_start` input 1: write request, level-sensitive.
- `sccb_address` input 8: register sub-address. Sampled on acceptance.
- `sccb_data` input 8: register data. Sampled on acceptance.
- `siod_in` input 1: SIO_D pad readback. Used only under `SCCB_ACK_CHECK_EN`.
- `sccb_ready` output 1: high when idle and able to accept a request.
- `sioc` output 1: SIO_C, push-pull.
- `siod_out` output 1: SIO_D output value.
- `siod_oe` output 1: SIO_D output enable. 1 = drive, 0 = release.
- `ack_err` output 1: don't-care bit read back high. Sticky until the next acceptance.

## Operation
- States: IDLE, SETTLE, START, SHIFT, STOP.
  - Counters: quarter-cycle counter, quarter index 0–3, bit index 0–26.
- **Reset values:** sioc=1, siod_out=1, siod_oe=1, sccb_ready=0, ack_err=0. State resets to SETTLE.
- **SETTLE:** lasts exactly one cycle, sets sccb_ready=1, then goes to IDLE.
- **IDLE:** acceptance occurs on a clock edge where sccb_start=1 and the state is IDLE.
  - sccb_ready has therefore been high for at least one full cycle before any acceptance.
  - This gives a sequencer that updates address/data on seeing ready (while holding start high) one cycle to present new values. The same write is never repeated.
- **On acceptance:**
  - Latch address and data; the latched copies are used for the whole frame.
  - Clear ack_err, set sccb_ready=0, go to START.
- **Quarter behaviour within each bit:**
  - Q0: sioc=0, siod updated.
  - Q1: sioc=0.
  - Q2 and Q3: sioc=1.
- **START:** Q0–Q1 sioc=1, siod=1. Q2–Q3 sioc=1, siod=0.
- **SHIFT:** 27 bits in three phases of 9 bits, each byte sent MSB first.
  - Phase 1: DEV_ADDR[7:0].
  - Phase 2: sub-address.
  - Phase 3: data.
  - The 9th bit of each phase is don't-care: siod_oe=0, siod_out=1.
- **STOP:**
  - Q0–Q1: sioc=0, siod=0.
  - Q2: sioc=1, siod=0.
  - Q3: sioc=1, siod=1.
  - Then go to SETTLE.
- sccb_start is ignored outside IDLE. Input changes during a frame have no effect.
- Reset mid-frame: outputs return to reset values on the next edge, with no completion of the frame. The camera is resynchronised by the next START.

## Timing
- Every output is a registered signal driven directly from state, counter and latched-data flops.
- Total frame length is 116 quarters (4 START + 108 SHIFT + 4 STOP).
- Edge numbering takes the acceptance edge as edge 0.
  - The first START quarter begins at edge 1.
  - sccb_ready rises at edge 116·QUARTER_CYCLES + 1, which is 7193 with defaults.
  - The earliest next acceptance is at edge 116·QUARTER_CYCLES + 2.
- After reset deasserts: sccb_ready=1 one cycle later, and the earliest acceptance is the following edge.
- siod changes only while sioc=0, except at the START and STOP transitions.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - siod_in is sampled on the last cycle of Q2 of each don't-care bit.
  - A 1 sets ack_err, which stays set until the next acceptance.
  - The frame always completes; there is no abort.
- `SCCB_ACK_CHECK_EN` undefined: siod_in is unused and ack_err is tied to 0.

## Test plan
- **Reset:** hold rst_25M for 3 cycles.
  - During reset: sioc=1, siod_out=1, siod_oe=1, sccb_ready=0, ack_err=0.
  - sccb_ready=1 one cycle after release.
- **Single write:** address=8'h12, data=8'h80, pulse start.
  - Bits captured on sioc rising edges decode to 0x42, X, 0x12, X, 0x80, X.
  - siod_oe=0 during the three X bits.
  - START and STOP edges are correct.
  - sccb_ready is high again exactly 7193 cycles after acceptance.
- **Back-to-back writes:** start held high constantly; a sequencer model loads 12/80 then 11/01, updating on sccb_ready.
  - Exactly two frames, carrying 0x12/0x80 then 0x11/0x01.
  - No duplicated frame.
- **Inputs ignored mid-frame:** toggle sccb_start and change address to 8'hFF during SHIFT.
  - The frame still carries the latched values.
  - No second frame starts until ready re-asserts.
- **Ack check:** force siod_in=1 during the phase-2 don't-care bit.
  - With `SCCB_ACK_CHECK_EN`: ack_err=1 after that sample, cleared at the next acceptance.
  - Without the macro: ack_err stays 0.
- **Reset mid-frame:** assert rst_25M in bit 10.
  - Next edge: sioc=1, siod=1, sccb_ready=0.
  - A following write completes correctly.
